instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, prefetch FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mem_req  output  1  fetch request to instruction memory.
REQ-006 SHALL have port mem_addr  output  `word_width  fetch address, word aligned.
REQ-007 SHALL have port mem_gnt  input  1  request accepted this cycle.
REQ-008 SHALL have port mem_rvalid  input  1  read data valid; responses return in request order.
REQ-009 SHALL have port mem_rdata  input  `word_width  fetched instruction word.
REQ-010 SHALL have port instr_valid  output  1  instruction presented to decode.
REQ-011 SHALL have port instr_ready  input  1  decode accepts presented instruction.
REQ-012 SHALL have port instruction  output  `word_width  instruction to decode.
REQ-013 SHALL have port instr_pc  output  `word_width  address of presented instruction.
REQ-014 SHALL have port redirect  input  1  branch/jump taken; flush and refetch.
REQ-015 SHALL have port redirect_pc  input  `word_width  new fetch address.
REQ-016 SHALL have port fifo_count  output  log2(DEPTH)+1  valid FIFO entries.

Function
REQ-017 SHALL transfer an instruction only on a cycle with instr_valid=1 and instr_ready=1; instruction/instr_pc SHALL be stable while instr_valid=1 and instr_ready=0.
REQ-018 SHALL hold a fetch PC; each mem_req with mem_gnt=1 SHALL advance it by 4, wrapping 32'hFFFF_FFFC -> 0.
REQ-019 SHALL track outstanding (granted, not returned) requests; mem_req SHALL assert only when outstanding + fifo_count < DEPTH (credit rule), so FIFO never overflows.
REQ-020 SHALL implement FSM states FETCH, STALL, DRAIN.
REQ-021 FETCH: mem_req=1; go STALL when credits reach 0.
REQ-022 STALL: mem_req=0; return to FETCH when a credit frees (pop or neither).
REQ-023 On redirect=1: FIFO flushed, fetch PC := redirect_pc with bits [1:0] forced 0, all outstanding requests (including any granted that cycle) marked stale; go DRAIN if stale count >0, else FETCH.
REQ-024 DRAIN: mem_req=0; each mem_rvalid decrements stale count and its data is discarded; go FETCH next cycle after stale count reaches 0.
REQ-025 A non-stale mem_rvalid SHALL push {mem_rdata, its PC} into FIFO; visible on outputs no earlier than next cycle (without REQ-034 bypass).
REQ-026 Push and pop in the same cycle SHALL leave fifo_count unchanged; FIFO pointers wrap modulo DEPTH.
REQ-027 Redirect coincident with a handshake: the instruction SHALL count as accepted, then flushed; redirect coincident with mem_rvalid: data discarded.
REQ-028 Redirect during DRAIN SHALL update fetch PC and add any new grants to stale count; remain in DRAIN.
REQ-029 instr_valid SHALL equal (fifo_count != 0) except under REQ-034 bypass.

Reset
REQ-030 While rst=0: mem_req=0, mem_addr=RESET_PC, instr_valid=0, instruction=0, instr_pc=0, fifo_count=0, outstanding=0, stale=0, state=FETCH.
REQ-031 First mem_req=1 SHALL occur in the first cycle after rst deasserts; reset mid-operation discards all FIFO contents and in-flight responses.

Configuration
REQ-032 Macro FETCH_BYPASS_EN SHALL select same-cycle bypass.
REQ-033 Without FETCH_BYPASS_EN: minimum rvalid-to-instr_valid latency 1 cycle.
REQ-034 With FETCH_BYPASS_EN: when FIFO empty, not redirecting, and non-stale mem_rvalid=1, instr_valid=1 combinationally with mem_rdata; if instr_ready=1 the entry is not pushed, else it is pushed.

Verification
REQ-035 Reset release, memory grants every cycle, 1-cycle rvalid -> addresses 0,4,8,..; instr_pc matches; one instruction per cycle with instr_ready=1.
REQ-036 instr_ready=0 held, DEPTH=4 -> exactly 4 grants, mem_req=0, fifo_count=4, instruction stable.
REQ-037 Redirect to 32'h0000_0103 with 2 outstanding -> next request addr 0x100 only after 2 rvalids discarded; no stale word reaches decode.
REQ-038 Fetch PC at 32'hFFFF_FFFC, grant -> next mem_addr 0.
REQ-039 Redirect, instr handshake and rvalid same cycle -> fifo_count=0 next cycle, handshaken word consumed once.
REQ-040 FETCH_BYPASS_EN, empty FIFO, rvalid with instr_ready=1 -> instr_valid same cycle, fifo_count stays 0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: credit-limited memory requests, in-order responses, prefetch FIFO to decode.
// Optional macro FETCH_BYPASS_EN forwards a live response to decode in the same cycle when the FIFO is empty.
module instr_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    mem_req,
    output logic [31:0]             mem_addr,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [31:0]             mem_rdata,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    output logic [31:0]             instruction,
    output logic [31:0]             instr_pc,
    input  logic                    redirect,
    input  logic [31:0]             redirect_pc,
    output logic [$clog2(DEPTH):0]  fifo_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {FETCH, STALL, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] out_q, out_d, stale_q, stale_d, count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW:0]   occupancy, occ_next;
    logic [31:0]   data_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];
    logic          credit_ok, grant, rsp_live, bypass, push, pop;
    logic [31:0]   rsp_pc;

    assign occupancy = {1'b0, out_q} + {1'b0, count_q};
    assign credit_ok = occupancy < (CW+1)'(DEPTH);
    assign mem_req   = rst && (state_q == FETCH) && credit_ok;
    assign mem_addr  = fetch_pc_q & ~32'h3;
    assign grant     = mem_req && mem_gnt;
    assign rsp_live  = mem_rvalid && (stale_q == '0);
    // Responses arrive in order, so the oldest live request sits 4*out_q bytes behind the fetch PC.
    assign rsp_pc    = fetch_pc_q - 32'({out_q, 2'b00});

`ifdef FETCH_BYPASS_EN
    assign bypass = rst && rsp_live && !redirect && (count_q == '0);
`else
    assign bypass = 1'b0;
`endif

    assign instr_valid = (count_q != '0) || bypass;
    assign fifo_count  = count_q;
    assign pop         = instr_ready && (count_q != '0);
    assign push        = rsp_live && !redirect && !(bypass && instr_ready);

    always_comb begin
        instruction = '0;
        instr_pc    = '0;
        if (count_q != '0) begin
            instruction = data_mem[rd_ptr_q];
            instr_pc    = pc_mem[rd_ptr_q];
        end else if (bypass) begin
            instruction = mem_rdata;
            instr_pc    = rsp_pc;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = grant ? fetch_pc_q + 32'd4 : fetch_pc_q;
        out_d      = out_q;
        stale_d    = stale_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_next   = '0;
        if (redirect) begin
            // Everything in flight, including a grant this cycle, becomes stale.
            fetch_pc_d = redirect_pc & ~32'h3;
            stale_d    = stale_q + out_q + CW'(grant) - CW'(mem_rvalid);
            out_d      = '0;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            state_d    = (stale_d != '0) ? DRAIN : FETCH;
        end else begin
            if (mem_rvalid) begin
                if (stale_q != '0) stale_d = stale_q - 1'b1;
                else               out_d   = out_q - 1'b1;
            end
            if (grant) out_d    = out_d + 1'b1;
            if (push)  wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q + CW'(push) - CW'(pop);
            occ_next = {1'b0, out_d} + {1'b0, count_d};
            unique case (state_q)
                FETCH:   if (occ_next >= (CW+1)'(DEPTH)) state_d = STALL;
                STALL:   if (occ_next <  (CW+1)'(DEPTH)) state_d = FETCH;
                DRAIN:   if (stale_d == '0)              state_d = FETCH;
                default: state_d = FETCH;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            out_q      <= '0;
            stale_q    <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            out_q      <= out_d;
            stale_q    <= stale_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // NOTE: FIFO storage is not reset; count_q gates every read, so old contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= mem_rdata;
            pc_mem[wr_ptr_q]   <= rsp_pc;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: in-order 1-cycle memory model plus an in-order decode scoreboard.
module tb_instr_fetch_unit;
`ifdef FETCH_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_rdata;
    logic        instr_valid, instr_ready;
    logic [31:0] instruction, instr_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [2:0]  fifo_count;

    int          total = 0;
    int          bad   = 0;
    int          acc_cnt = 0;
    int          gnt_cnt = 0;
    logic [31:0] exp_pc = '0;
    bit          rsp_en = 1'b1;
    logic [31:0] pend_q [$];

    instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .instr_pc(instr_pc),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: score any handshake, record a grant, then drive the memory response for the next cycle.
    task automatic step();
        logic        g;
        logic [31:0] ga;
        #1;
        if (instr_valid && instr_ready) begin
            check("dec_pc", instr_pc, exp_pc);
            check("dec_word", instruction, word_of(exp_pc));
            exp_pc += 32'd4;
            acc_cnt++;
        end
        g  = mem_req && mem_gnt;
        ga = mem_addr;
        if (g) gnt_cnt++;
        @(posedge clk);
        #1;
        if (g) pend_q.push_back(ga);
        if (rsp_en && pend_q.size() != 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = word_of(pend_q.pop_front());
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end
        redirect = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset(input logic ready);
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = ready;
        mem_gnt     = 1'b1;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        rsp_en      = 1'b1;
        pend_q.delete();
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset values
        rst = 1'b0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
        mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_insn", instruction, 32'h0);
        check("rst_pc", instr_pc, 32'h0);
        check("rst_count", 32'(fifo_count), 32'd0);

        // Streaming fetch, grant every cycle, decode always ready
        rst = 1'b1;
        #1;
        exp_pc = '0; acc_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == 0) check("first_req", 32'(mem_req), 32'd1);
            check("stream_addr", mem_addr, 32'(k * 4));
            if (k == 1) begin
                check("lat_valid", 32'(instr_valid), 32'(BYP));
                check("lat_count", 32'(fifo_count), 32'd0);
                if (BYP == 1) begin
                    check("byp_pc", instr_pc, 32'h0);
                    check("byp_word", instruction, word_of(32'h0));
                end
            end
            step();
        end
        check("stream_acc", 32'(acc_cnt), 32'(8 + BYP));
        check("stream_count", 32'(fifo_count), 32'(1 - BYP));

        // Reset mid-operation, then decode stalled: FIFO fills to DEPTH
        rst = 1'b0;
        #1;
        check("midrst_count", 32'(fifo_count), 32'd0);
        check("midrst_valid", 32'(instr_valid), 32'd0);
        check("midrst_req", 32'(mem_req), 32'd0);
        do_reset(1'b0);
        gnt_cnt = 0;
        repeat (12) step();
        check("full_grants", 32'(gnt_cnt), 32'd4);
        check("full_req", 32'(mem_req), 32'd0);
        check("full_count", 32'(fifo_count), 32'd4);
        check("full_pc", instr_pc, 32'h0);
        repeat (3) step();
        check("hold_word", instruction, word_of(32'h0));
        check("hold_pc", instr_pc, 32'h0);
        instr_ready = 1'b1;
        exp_pc = '0; acc_cnt = 0;
        repeat (10) step();
        check("drain_acc", 32'(acc_cnt), 32'd10);

        // Redirect to misaligned target with two requests outstanding
        do_reset(1'b1);
        rsp_en = 1'b0;
        step();
        step();
        mem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0103;
        step();
        mem_gnt = 1'b1;
        check("drn_req0", 32'(mem_req), 32'd0);
        rsp_en = 1'b1;
        step();
        check("drn_req1", 32'(mem_req), 32'd0);
        check("drn_valid1", 32'(instr_valid), 32'd0);
        check("drn_count1", 32'(fifo_count), 32'd0);
        step();
        check("drn_req2", 32'(mem_req), 32'd0);
        check("drn_valid2", 32'(instr_valid), 32'd0);
        step();
        check("redir_req", 32'(mem_req), 32'd1);
        check("redir_addr", mem_addr, 32'h0000_0100);
        exp_pc = 32'h0000_0100; acc_cnt = 0;
        repeat (6) step();
        check("redir_acc", 32'(acc_cnt), 32'(4 + BYP));

        // Fetch PC wrap from the top of the address space
        do_reset(1'b1);
        exp_pc = 32'hFFFF_FFF8; acc_cnt = 0;
        mem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        step();
        mem_gnt = 1'b1;
        check("wrap_addr0", mem_addr, 32'hFFFF_FFF8);
        step();
        check("wrap_addr1", mem_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_addr2", mem_addr, 32'h0000_0000);
        repeat (5) step();
        check("wrap_acc", 32'(acc_cnt), 32'(5 + BYP));

        // Redirect, handshake and rvalid in the same cycle
        do_reset(1'b0);
        step();
        step();
        check("co_valid", 32'(instr_valid), 32'd1);
        check("co_pc", instr_pc, 32'h0);
        check("co_rvalid", 32'(mem_rvalid), 32'd1);
        exp_pc = '0; acc_cnt = 0;
        instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
        step();
        check("co_acc", 32'(acc_cnt), 32'd1);
        check("co_count", 32'(fifo_count), 32'd0);
        check("co_valid2", 32'(instr_valid), 32'd0);
        check("co_req", 32'(mem_req), 32'd0);
        exp_pc = 32'h0000_0200;
        step();
        check("co_addr", mem_addr, 32'h0000_0200);
        acc_cnt = 0;
        repeat (4) step();
        check("co_acc2", 32'(acc_cnt), 32'(2 + BYP));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
